// File: rtl/alu_pkg.sv
// Shared types for the ALU select interface: opcode map, compare encoding
// and the sweep controller FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_OR  = 3'd1,
        ALU_SHR = 3'd2,
        ALU_SHL = 3'd3,
        ALU_ADD = 3'd4,
        ALU_SUB = 3'd5,
        ALU_CMP = 3'd6
    } alu_op_e;

    localparam logic [7:0] ALU_CMP_GT = 8'h01;
    localparam logic [7:0] ALU_CMP_LT = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_SEND  = 2'd2
    } sweep_state_e;

    // 2'b01 = x>y, 2'b10 = x<y, 2'b00 = equal or not a compare opcode
    function automatic logic [1:0] cmp_decode(input logic [2:0] op, input logic [7:0] z);
        logic [1:0] f;
        f = 2'b00;
        if (op == ALU_CMP) begin
            if (z == ALU_CMP_GT)      f = 2'b01;
            else if (z == ALU_CMP_LT) f = 2'b10;
        end
        return f;
    endfunction

endpackage

// File: rtl/alu_sweep_ctrl.sv
// Steps an external 8-bit ALU through opcodes 0..NUM_OPS-1 for one operand
// pair and streams each settled result out. Optional: ALU_SWEEP_CMP_DECODE_EN.
module alu_sweep_ctrl
    import alu_pkg::*;
#(
    parameter int SETTLE  = 1,
    parameter int NUM_OPS = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_valid,
    output logic       start_ready,
    input  logic [7:0] op_x,
    input  logic [7:0] op_y,
    output logic [7:0] alu_x,
    output logic [7:0] alu_y,
    output logic [2:0] alu_sel,
    input  logic [7:0] alu_z,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [2:0] res_op,
    output logic       res_last,
    output logic       busy
`ifdef ALU_SWEEP_CMP_DECODE_EN
    ,
    output logic [1:0] cmp_flag
`endif
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [2:0] LAST_OP     = 3'(NUM_OPS - 1);

    sweep_state_e state, state_nxt;
    logic [3:0]   cnt;
    logic         settled;

    assign settled = (cnt == SETTLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_valid)          state_nxt = ST_DRIVE;
            ST_DRIVE: if (settled)              state_nxt = ST_SEND;
            ST_SEND:  if (res_ready)            state_nxt = res_last ? ST_IDLE : ST_DRIVE;
            default:                            state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        start_ready = (state == ST_IDLE);
        busy        = (state != ST_IDLE);
        res_valid   = (state == ST_SEND);
    end

    // Operands and select only move on a start or a result handshake, so the
    // ALU inputs are quiet for the whole settle window and under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_x    <= '0;
            alu_y    <= '0;
            alu_sel  <= '0;
            cnt      <= '0;
            res_data <= '0;
            res_op   <= '0;
            res_last <= 1'b0;
`ifdef ALU_SWEEP_CMP_DECODE_EN
            cmp_flag <= 2'b00;
`endif
        end else begin
            case (state)
                ST_IDLE: if (start_valid) begin
                    alu_x   <= op_x;
                    alu_y   <= op_y;
                    alu_sel <= '0;
                    cnt     <= '0;
                end
                ST_DRIVE: begin
                    cnt <= cnt + 4'd1;
                    if (settled) begin
                        res_data <= alu_z;
                        res_op   <= alu_sel;
                        res_last <= (alu_sel == LAST_OP);
`ifdef ALU_SWEEP_CMP_DECODE_EN
                        cmp_flag <= cmp_decode(alu_sel, alu_z);
`endif
                    end
                end
                ST_SEND: if (res_ready && !res_last) begin
                    alu_sel <= alu_sel + 3'd1;
                    cnt     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
